// File: rtl/viterbi_pkg.sv
// Shared definitions for the hard-decision rate-1/2 Viterbi frame decoder:
// FSM state encoding, default trellis geometry and the small arithmetic
// helpers used by the add-compare-select units.
package viterbi_pkg;

    // Default constraint length and the matching trellis width.
    localparam int VIT_K   = 4;
    localparam int NSTATES = 1 << (VIT_K - 1);

    // Decoder control states.
    typedef enum logic [1:0] {
        ST_ACS    = 2'd0,
        ST_SELECT = 2'd1,
        ST_TRACE  = 2'd2,
        ST_DONE   = 2'd3
    } vit_state_t;

    // Encoder output for input bit b leaving state s. The tap vectors use
    // bit k-1 for the current input and bits k-2..0 for state MSB..LSB.
    function automatic logic [1:0] expected_symbol(
        input logic [31:0] g1,
        input logic [31:0] g0,
        input int          k,
        input logic        b,
        input logic [31:0] s
    );
        logic [31:0] word;
        word = s | ({31'd0, b} << (k - 1));
        return {^(g1 & word), ^(g0 & word)};
    endfunction

    // Hamming distance between an expected and a received 2-bit symbol.
    function automatic logic [1:0] branch_metric(
        input logic [1:0] exp_sym,
        input logic [1:0] rx_sym
    );
        logic [1:0] diff;
        diff = exp_sym ^ rx_sym;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // Add that clamps at the all-ones value of a w-bit metric. An operand
    // already at the clamp (unreachable state) stays clamped.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] max_v;
        logic [32:0] sum;
        max_v = (33'd1 << w) - 33'd1;
        if ({1'b0, a} >= max_v) begin
            return max_v[31:0];
        end
        sum = {1'b0, a} + {1'b0, b};
        if (sum > max_v) begin
            return max_v[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/viterbi_frame_decoder_acs.sv
// Compare-select for one trellis state: adds the branch metric to each of
// the two predecessor path metrics, keeps the smaller candidate and reports
// which predecessor won (0 = p0, 1 = p1; ties go to p0).
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [1:0]      i_bm0,
    input  logic [1:0]      i_bm1,
    output logic [PM_W-1:0] o_pm,
    output logic            o_dec
);

    logic [PM_W-1:0] w_cand0;
    logic [PM_W-1:0] w_cand1;

    // Saturating candidates, then a strict compare so equal metrics keep p0.
    always_comb begin
        w_cand0 = PM_W'(sat_add(32'(i_pm0), 32'(i_bm0), PM_W));
        w_cand1 = PM_W'(sat_add(32'(i_pm1), 32'(i_bm1), PM_W));
        o_dec   = (w_cand1 < w_cand0);
        o_pm    = o_dec ? w_cand1 : w_cand0;
    end

endmodule

// File: rtl/viterbi_frame_decoder.sv
// Hard-decision rate-1/2 Viterbi decoder working on one fixed-length frame
// at a time: FRAME_LEN trellis steps (one per accepted symbol), a one-cycle
// start-state selection, FRAME_LEN traceback cycles, then the decoded frame
// and its path metric are held until the consumer takes them.
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high. The input side is ready only while accumulating
// symbols; out_valid stays high with stable data until out_ready is seen,
// and exactly one frame moves per output transfer.
module viterbi_frame_decoder
    import viterbi_pkg::*;
#(
    parameter int           K         = VIT_K,
    parameter logic [K-1:0] G1        = 4'b1111,
    parameter logic [K-1:0] G0        = 4'b1101,
    parameter int           FRAME_LEN = 8,
    parameter int           PM_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [1:0]           i_sym_in,
    input  logic                 i_tb_mode,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [FRAME_LEN-1:0] o_out_bits,
    output logic [PM_W-1:0]      o_out_metric
);

    // Default geometry comes from the package; other K values derive it.
    localparam int N_ST  = (K == VIT_K) ? NSTATES : (1 << (K - 1));
    localparam int SW    = K - 1;
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};

    vit_state_t           r_state;
    vit_state_t           w_next_state;

    logic [PM_W-1:0]      r_pm     [N_ST];
    logic [PM_W-1:0]      w_pm_new [N_ST];
    logic [N_ST-1:0]      w_dec;
    logic [N_ST-1:0]      r_surv   [FRAME_LEN];

    logic [IDX_W-1:0]     r_step;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_tb_mode;
    logic [SW-1:0]        r_cur;
    logic [SW-1:0]        w_best;
    logic [PM_W-1:0]      w_best_pm;
    logic [FRAME_LEN-1:0] r_out_bits;
    logic [PM_W-1:0]      r_out_metric;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_out_take;

    assign w_accept   = i_in_valid & o_in_ready;
    assign w_last     = (r_step == LAST_IDX);
    assign w_out_take = o_out_valid & i_out_ready;

    // One ACS unit per state. State n is entered with input bit n[K-2]
    // from predecessors p0 = {n[K-3:0],0} and p1 = {n[K-3:0],1}; the
    // expected symbols along both branches are elaboration-time constants.
    for (genvar n = 0; n < N_ST; n++) begin : g_acs
        localparam int         P0 = (2 * n) % N_ST;
        localparam int         P1 = P0 + 1;
        localparam logic       B  = ((n >> (K - 2)) & 1) != 0;
        localparam logic [1:0] E0 = expected_symbol(32'(G1), 32'(G0), K, B, 32'(P0));
        localparam logic [1:0] E1 = expected_symbol(32'(G1), 32'(G0), K, B, 32'(P1));

        logic [1:0] w_bm0;
        logic [1:0] w_bm1;

        assign w_bm0 = branch_metric(E0, i_sym_in);
        assign w_bm1 = branch_metric(E1, i_sym_in);

        viterbi_acs_unit #(
            .PM_W (PM_W)
        ) u_acs (
            .i_pm0 (r_pm[P0]),
            .i_pm1 (r_pm[P1]),
            .i_bm0 (w_bm0),
            .i_bm1 (w_bm1),
            .o_pm  (w_pm_new[n]),
            .o_dec (w_dec[n])
        );
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ACS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: collect a frame, pick a start, trace back, hand off.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACS:    if (w_accept && w_last) w_next_state = ST_SELECT;
            ST_SELECT: w_next_state = ST_TRACE;
            ST_TRACE:  if (r_idx == '0) w_next_state = ST_DONE;
            ST_DONE:   if (i_out_ready) w_next_state = ST_ACS;
            default:   w_next_state = ST_ACS;
        endcase
    end

    // FSM outputs: input ready only while collecting, output valid in DONE.
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            ST_ACS:  o_in_ready  = 1'b1;
            ST_DONE: o_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Path metrics: start from state 0 only, update once per accepted
    // symbol, and restart after the decoded frame is handed off.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_ST; i++) begin
                r_pm[i] <= (i == 0) ? '0 : PM_MAX;
            end
        end else if (w_accept) begin
            for (int i = 0; i < N_ST; i++) begin
                r_pm[i] <= w_pm_new[i];
            end
        end else if (w_out_take) begin
            for (int i = 0; i < N_ST; i++) begin
                r_pm[i] <= (i == 0) ? '0 : PM_MAX;
            end
        end
    end

    // Step counter and traceback-mode capture on the first symbol of a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step    <= '0;
            r_tb_mode <= 1'b0;
        end else if (w_accept) begin
            if (r_step == '0) begin
                r_tb_mode <= i_tb_mode;
            end
            r_step <= w_last ? '0 : r_step + 1'b1;
        end else if (w_out_take) begin
            r_step <= '0;
        end
    end

    // Survivor memory: one decision bit per state for every trellis step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_surv[i] <= '0;
            end
        end else if (w_accept) begin
            r_surv[r_step] <= w_dec;
        end
    end

    // Start state: state 0 for tail-terminated frames, otherwise the
    // lowest-index state holding the minimum metric (state 0 when every
    // metric is saturated, since the compare is strict).
    always_comb begin
        w_best    = '0;
        w_best_pm = r_pm[0];
        if (!r_tb_mode) begin
            for (int i = 1; i < N_ST; i++) begin
                if (r_pm[i] < w_best_pm) begin
                    w_best_pm = r_pm[i];
                    w_best    = SW'(i);
                end
            end
        end
    end

    // Start selection and traceback: each step emits the state MSB as the
    // decoded bit and shifts the stored decision in as the predecessor LSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur        <= '0;
            r_idx        <= '0;
            r_out_bits   <= '0;
            r_out_metric <= '0;
        end else begin
            case (r_state)
                ST_SELECT: begin
                    r_cur        <= w_best;
                    r_idx        <= LAST_IDX;
                    r_out_metric <= r_pm[w_best];
                end
                ST_TRACE: begin
                    r_out_bits[r_idx] <= r_cur[SW-1];
                    r_cur             <= {r_cur[SW-2:0], r_surv[r_idx][r_cur]};
                    r_idx             <= r_idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_out_bits   = r_out_bits;
    assign o_out_metric = r_out_metric;

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Self-checking bench for viterbi_frame_decoder: fixed vector table,
// hand-built handshake and reset sequences, and random frames checked
// against an exhaustive maximum-likelihood reference.
module tb_viterbi_frame_decoder;

    localparam int         FL      = 8;
    localparam int         TIMEOUT = 40;
    localparam logic [3:0] TAP1    = 4'b1111;
    localparam logic [3:0] TAP0    = 4'b1101;

    // ---------------- clock / reset / DUT ----------------
    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [1:0]    sym_in    = 2'd0;
    logic          tb_mode   = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FL-1:0] out_bits;
    logic [7:0]    out_metric;

    always #5 clk = ~clk;

    viterbi_frame_decoder #(
        .K         (4),
        .G1        (TAP1),
        .G0        (TAP0),
        .FRAME_LEN (FL),
        .PM_W      (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_sym_in     (sym_in),
        .i_tb_mode    (tb_mode),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_bits   (out_bits),
        .o_out_metric (out_metric)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    // {unique, start[2:0], metric[7:0], bits[7:0]}
    logic [19:0] exp_q[$];
    // symbol i of the current frame lives at [2i+1:2i]
    logic [15:0] rx_syms;

    typedef struct {
        logic [15:0] syms;
        logic        mode;
        logic [7:0]  bits;
        logic [7:0]  metric;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] pack8(input logic [1:0] s0, input logic [1:0] s1,
                                          input logic [1:0] s2, input logic [1:0] s3,
                                          input logic [1:0] s4, input logic [1:0] s5,
                                          input logic [1:0] s6, input logic [1:0] s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    // ---------------- reference model ----------------
    // Convolutional encoder from the all-zero state.
    function automatic logic [15:0] encode(input logic [7:0] bits);
        logic [2:0]  st;
        logic [3:0]  word;
        logic [15:0] s;
        st = 3'd0;
        s  = '0;
        for (int t = 0; t < FL; t++) begin
            word         = {bits[t], st};
            s[2*t +: 2]  = {^(word & TAP1), ^(word & TAP0)};
            st           = {bits[t], st[2:1]};
        end
        return s;
    endfunction

    // Exhaustive ML search: best distance per end state (last three input
    // bits), the chosen start state, and the path itself when it is the only
    // one achieving that distance into that end state.
    function automatic logic [19:0] model(input logic [15:0] rx, input logic mode);
        int         best[8];
        int         d;
        int         start;
        int         cnt;
        logic [7:0] b;
        logic [7:0] ubits;
        for (int i = 0; i < 8; i++) best[i] = 1000;
        for (int seq = 0; seq < 256; seq++) begin
            b = 8'(seq);
            d = $countones(encode(b) ^ rx);
            if (d < best[b[7:5]]) best[b[7:5]] = d;
        end
        start = 0;
        if (!mode) begin
            for (int i = 1; i < 8; i++) if (best[i] < best[start]) start = i;
        end
        cnt   = 0;
        ubits = '0;
        for (int seq = 0; seq < 256; seq++) begin
            b = 8'(seq);
            if (int'(b[7:5]) == start && $countones(encode(b) ^ rx) == best[start]) begin
                cnt++;
                ubits = b;
            end
        end
        return {(cnt == 1), 3'(start), 8'(best[start]), ubits};
    endfunction

    // ---------------- driver / collector ----------------
    // Feeds rx_syms (optional idle gaps, tb_mode flipped after the first
    // symbol), then waits for the frame, optionally holds out_ready low and
    // optionally keeps offering junk symbols while the decoder is busy.
    task automatic run_frame(input logic mode, input int gap_max, input int hold, input bit junk);
        int          cycles;
        int          busy_err;
        int          stable_err;
        logic [19:0] e;
        logic [7:0]  got_bits;
        logic [7:0]  got_metric;

        for (int i = 0; i < FL; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                sym_in   = 2'($urandom);
                tb_mode  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            sym_in   = rx_syms[2*i +: 2];
            tb_mode  = (i == 0) ? mode : ~mode;
            check("in_ready_collect", in_ready, 1);
            @(negedge clk);
        end

        in_valid = junk;
        sym_in   = 2'($urandom);
        cycles     = 1;
        busy_err   = 0;
        stable_err = 0;
        while (!out_valid && cycles < TIMEOUT) begin
            if (in_ready) busy_err++;
            if (junk) sym_in = 2'($urandom);
            @(negedge clk);
            cycles++;
        end
        check("latency", cycles, 10);

        got_bits   = out_bits;
        got_metric = out_metric;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (in_ready) busy_err++;
            if (!out_valid || out_bits !== got_bits || out_metric !== got_metric) stable_err++;
            if (junk) sym_in = 2'($urandom);
            @(negedge clk);
        end
        if (in_ready) busy_err++;
        check("in_ready_busy", busy_err, 0);
        if (hold > 0) check("hold_stable", stable_err, 0);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_return", in_ready, 1);

        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
        check("metric", got_metric, e[15:8]);
        if (e[19]) begin
            check("bits", got_bits, e[7:0]);
        end else begin
            check("path_distance", $countones(encode(got_bits) ^ rx_syms), e[15:8]);
            check("path_end_state", got_bits[7:5], e[18:16]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0]  rb;
        logic [15:0] rx;
        logic        rmode;

        vecs[0] = '{pack8(3,3,1,3,1,1,3,0), 1'b0, 8'b0000_1101, 8'd0};
        vecs[1] = '{pack8(3,3,0,3,1,1,3,0), 1'b0, 8'b0000_1101, 8'd1};
        vecs[2] = '{pack8(0,0,0,0,0,0,0,0), 1'b1, 8'b0000_0000, 8'd0};
        vecs[3] = '{pack8(3,3,1,3,1,1,3,0), 1'b1, 8'b0000_1101, 8'd0};
        vecs[4] = '{pack8(3,3,1,3,1,1,3,0), 1'b0, 8'b0000_1101, 8'd0};
        vecs[5] = '{pack8(2,3,1,3,1,0,3,0), 1'b0, 8'b0000_1101, 8'd2};

        // reset values while reset is held
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_bits", out_bits, 0);
        check("reset_out_metric", out_metric, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // table vectors, back-to-back frames
        for (int v = 0; v < 6; v++) begin
            rx_syms = vecs[v].syms;
            exp_q.push_back({1'b1, 3'd0, vecs[v].metric, vecs[v].bits});
            run_frame(vecs[v].mode, 0, 0, 1'b0);
        end

        // input gaps, junk offered while busy, out_ready held low 5 cycles
        rx_syms = vecs[0].syms;
        exp_q.push_back({1'b1, 3'd0, 8'd0, 8'b0000_1101});
        run_frame(1'b0, 3, 5, 1'b1);

        // reset after four symbols of a partial frame
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            sym_in   = 2'($urandom);
            tb_mode  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_bits", out_bits, 0);
        check("midreset_out_metric", out_metric, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx_syms = vecs[0].syms;
        exp_q.push_back({1'b1, 3'd0, 8'd0, 8'b0000_1101});
        run_frame(1'b0, 0, 0, 1'b0);

        // random frames against the exhaustive reference
        for (int f = 0; f < 24; f++) begin
            rmode = 1'($urandom);
            rb    = 8'($urandom);
            if (rmode) rb[7:5] = 3'b000;
            rx = encode(rb);
            if ($urandom_range(0, 3) == 0) begin
                rx = 16'($urandom);
            end else begin
                for (int j = 0; j < 16; j++) begin
                    if ($urandom_range(0, 9) == 0) rx[j] = ~rx[j];
                end
            end
            rx_syms = rx;
            exp_q.push_back(model(rx, rmode));
            run_frame(rmode, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
